io_in_port: RTL and testbench
=============================

# io_in_port

Memory-mapped, debounced input port for the pipelined CPU: the read-side counterpart of the CPU's LED output path. It samples up to 8 asynchronous board switches/buttons, synchronizes and debounces each bit, and latches rising and falling edges into read-to-clear registers. It raises a maskable interrupt request. It sits beside the data memory on the CPU's data bus and is clocked by the master clock `clk`.

## Interface
- `WIDTH`, default 8: number of input pins, 1..8.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive mismatching cycles needed to accept a new level, 2..65535.

- `clk`  in  1  master clock; all logic samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pins`  in  WIDTH  raw asynchronous inputs.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  2  read register select.
- `rd_data`  out  16  registered read data.
- `rd_valid`  out  1  high for exactly one cycle when `rd_data` is valid.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  2  write register select.
- `wr_data`  in  16  write data.
- `irq`  out  1  registered interrupt request, level-sensitive.

## Operation
- **Register map** (16-bit; unused high bits read 0):
  - 0 LEVEL (RO): debounced level.
  - 1 RISE (RO, read-to-clear): rising-edge latches.
  - 2 FALL (RO, read-to-clear): falling-edge latches.
  - 3 MASK (RW): [7:0] rise enable, [15:8] fall enable.
- **Per-bit synchronizer:** two flops, `s1 <= pin`, `s2 <= s1`.
- **Per-bit debounce counter:** 16 bits.
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and set the RISE bit (if `s2`=1) or the FALL bit (if `s2`=0).
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` consecutive mismatching cycles never changes `stable`.
- **Reads:**
  - When `rd_en` is high, `rd_data` loads the addressed register and `rd_valid` <= 1. Otherwise `rd_valid` <= 0, and `rd_data` holds its value.
  - Reading RISE or FALL clears exactly the bits returned, on the same edge.
- **Writes:** `wr_en` with `wr_addr`=3 loads MASK. Writes to addresses 0–2 are ignored.
- **Interrupt:** `irq <= |(RISE & MASK[7:0]) | |(FALL & MASK[15:8])`, computed from register values before the current edge's update.
- **Collisions:**
  - A new edge and a read-clear on the same bit in the same cycle: set wins, and the bit stays 1.
  - Read of MASK in the same cycle as a write to MASK: returns the old MASK.
  - `rd_en` and `wr_en` together on different registers: both take effect.
- **Reset:** `s1`, `s2`, `stable`, `cnt`, RISE, FALL, MASK, `rd_data`, `rd_valid` and `irq` all go to 0. A pin held high through reset produces one RISE event after the debounce time. This is intended; software clears it at boot.
- `rst` mid-debounce discards the partial count.

## Timing
- Pin change first sampled into `s1` at edge k.
- `stable`, LEVEL and the RISE/FALL bit update at edge k+1+`DEBOUNCE_CYCLES`.
- `irq` asserts at edge k+2+`DEBOUNCE_CYCLES` (if enabled).
- Read latency is 1 cycle: `rd_en` sampled at edge n gives `rd_data`/`rd_valid` valid after edge n and de-asserted after n+1 (unless `rd_en` is held).
- Back-to-back reads are allowed every cycle.
- `irq` drops one edge after the clearing read, provided no new enabled edge arrived.
- MASK write at edge n affects `irq` from edge n+1 onward.

## Test plan
1. **Debounce, rise.** DEBOUNCE_CYCLES=4. Reset, then `pins`=8'h01 sampled at edge 0 → LEVEL=16'h0001 and RISE=16'h0001 at edge 5; with MASK=16'h00FF, `irq`=1 at edge 6.
2. **Glitch rejection.** Pin 3 high for 3 cycles then low (D=4) → LEVEL, RISE and FALL stay 0, and `irq` stays 0.
3. **Read-to-clear.** After scenario 1, read addr 1 → `rd_data`=16'h0001 with `rd_valid` for one cycle. The next read of addr 1 returns 16'h0000, and `irq` falls one cycle after the first read.
4. **Set-wins collision.** Arrange for pin 0's falling-edge accept to coincide with a read of addr 2 where FALL=16'h0000 → `rd_data`=16'h0000, and FALL=16'h0001 afterwards.
5. **Mask behaviour.** MASK=16'h0100, toggle pin 0 high then low → no `irq` on the rise, `irq`=1 after the fall. Writing MASK=0 drops `irq` one edge later. Reading addr 3 in the same cycle as the write returns 16'h0100.
6. **Reset mid-operation.** Assert `rst` at count 2 of 4 with RISE=16'h0080 → every output is 0 the edge after, and MASK reads 0.

Source files
------------

// File: rtl/io_in_port.sv
// io_in_port: memory-mapped, debounced input port for the pipelined CPU.
// Each pin is synchronized, debounced, and its accepted edges are latched into
// read-to-clear RISE/FALL registers. The interrupt request is maskable.
module io_in_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  input  logic             rd_en,
  input  logic [1:0]       rd_addr,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [15:0]      wr_data,
  output logic             irq
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0] accept, rise_clr, fall_clr;
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [15:0]      mask_q, mask_d;
  logic [15:0]      rd_mux, rd_data_q, rd_data_d;
  logic             rd_valid_q, irq_q, irq_d;

  // Per-bit debounce: count consecutive mismatches and accept the new level
  // once the count reaches DEBOUNCE_CYCLES-1 on a still-mismatching cycle.
  always_comb begin
    accept   = '0;
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = 16'd0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept[i]   = 1'b1;
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Register file read mux; unused high bits read as zero.
  always_comb begin
    rd_mux = 16'd0;
    case (rd_addr)
      2'd0:    rd_mux[WIDTH-1:0] = stable_q;
      2'd1:    rd_mux[WIDTH-1:0] = rise_q;
      2'd2:    rd_mux[WIDTH-1:0] = fall_q;
      default: rd_mux            = mask_q;
    endcase
  end

  // Edge latches: a read clears exactly the bits it returned, but a new edge
  // accepted on the same cycle takes priority. irq uses pre-update values.
  always_comb begin
    rise_clr  = (rd_en && rd_addr == 2'd1) ? rise_q : '0;
    fall_clr  = (rd_en && rd_addr == 2'd2) ? fall_q : '0;
    rise_d    = (rise_q & ~rise_clr) | (accept & s2_q);
    fall_d    = (fall_q & ~fall_clr) | (accept & ~s2_q);
    mask_d    = (wr_en && wr_addr == 2'd3) ? wr_data : mask_q;
    rd_data_d = rd_en ? rd_mux : rd_data_q;
    irq_d     = (|(rise_q & mask_q[WIDTH-1:0])) | (|(fall_q & mask_q[8 +: WIDTH]));
  end

  // State update with synchronous reset of every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      mask_q     <= 16'd0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= 16'd0;
    end else begin
      s1_q       <= pins;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_io_in_port.sv
// Testbench for io_in_port: directed scenarios followed by randomized traffic,
// checked by a scoreboard fed from a behavioural model of the register map.
module tb_io_in_port;

  localparam int D = 4;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [7:0]  pins = 8'h00;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic        irq;

  io_in_port #(.WIDTH(8), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .pins(pins),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic irq;
    logic was_rst;
  } cyc_exp_t;

  cyc_exp_t    exp_cyc[$];
  logic [15:0] exp_rd[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  // Behavioural model: pins reach the debouncer after two cycles; a level is
  // accepted after D consecutive cycles of disagreement with the current one.
  logic [7:0]  m_p1, m_p2, m_level, m_rise, m_fall;
  logic [15:0] m_mask;
  int          m_run [8];

  task automatic model_step(input logic [7:0] p, input logic re, input logic [1:0] ra,
                            input logic we, input logic [1:0] wa, input logic [15:0] wd,
                            input logic r);
    cyc_exp_t e;
    logic [7:0]  nrise, nfall, nlevel;
    logic [15:0] val;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_mask = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      e.irq = 1'b0; e.was_rst = 1'b1;
      exp_cyc.push_back(e);
      return;
    end
    e.irq = ((m_rise & m_mask[7:0]) != 0) || ((m_fall & m_mask[15:8]) != 0);
    e.was_rst = 1'b0;
    exp_cyc.push_back(e);
    nrise = m_rise; nfall = m_fall;
    if (re) begin
      case (ra)
        2'd0: val = {8'h00, m_level};
        2'd1: begin val = {8'h00, m_rise}; nrise = 8'h00; end
        2'd2: begin val = {8'h00, m_fall}; nfall = 8'h00; end
        default: val = m_mask;
      endcase
      exp_rd.push_back(val);
    end
    nlevel = m_level;
    for (int i = 0; i < 8; i++) begin
      if (m_p2[i] == m_level[i]) m_run[i] = 0;
      else if (m_run[i] + 1 >= D) begin
        m_run[i] = 0;
        nlevel[i] = m_p2[i];
        if (m_p2[i]) nrise[i] = 1'b1; else nfall[i] = 1'b1;
      end else m_run[i] = m_run[i] + 1;
    end
    m_level = nlevel; m_rise = nrise; m_fall = nfall;
    if (we && wa == 2'd3) m_mask = wd;
    m_p2 = m_p1; m_p1 = p;
  endtask

  task automatic cyc(input logic [7:0] p, input logic re, input logic [1:0] ra,
                     input logic we, input logic [1:0] wa, input logic [15:0] wd,
                     input logic r);
    @(negedge clk);
    pins = p; rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; rst = r;
    model_step(p, re, ra, we, wa, wd, r);
  endtask

  task automatic idle(input int n, input logic [7:0] p);
    for (int i = 0; i < n; i++) cyc(p, 0, 2'd0, 0, 2'd0, 16'd0, 0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] p);
    cyc(p, 1, a, 0, 2'd0, 16'd0, 0);
  endtask

  task automatic wr_mask(input logic [15:0] v, input logic [7:0] p);
    cyc(p, 0, 2'd0, 1, 2'd3, v, 0);
  endtask

  // Monitor: one expected irq per edge; read data popped whenever rd_valid.
  initial begin
    cyc_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        n_checks++;
        if (exp_cyc.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: no expected entry at t=%0t", $time);
        end else begin
          e = exp_cyc.pop_front();
          if (irq !== e.irq) begin
            n_fail++;
            $display("FAIL irq: got %b expected %b at t=%0t", irq, e.irq, $time);
          end
          if (e.was_rst) begin
            n_checks++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
              n_fail++;
              $display("FAIL reset_outputs: rd_valid=%b rd_data=%h expected 0/0000 at t=%0t",
                       rd_valid, rd_data, $time);
            end
          end
        end
        if (rd_valid === 1'b1) begin
          n_checks++;
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: rd_valid with data %h, none expected at t=%0t", rd_data, $time);
          end else begin
            logic [15:0] x;
            x = exp_rd.pop_front();
            if (rd_data !== x) begin
              n_fail++;
              $display("FAIL rd_data: got %h expected %h at t=%0t", rd_data, x, $time);
            end
          end
        end else if (rd_valid !== 1'b0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_valid_x: got %b expected 0/1 at t=%0t", rd_valid, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] p;
    // Reset
    cyc(8'h00, 0, 2'd0, 0, 2'd0, 16'd0, 1);
    cyc(8'h00, 0, 2'd0, 0, 2'd0, 16'd0, 1);
    rd(2'd0, 8'h00); rd(2'd1, 8'h00); rd(2'd2, 8'h00); rd(2'd3, 8'h00);
    // Debounce rise with rise interrupts enabled
    wr_mask(16'h00FF, 8'h00);
    idle(8, 8'h01);
    rd(2'd0, 8'h01);
    // Read-to-clear
    rd(2'd1, 8'h01);
    rd(2'd1, 8'h01);
    idle(2, 8'h01);
    // Glitch rejection on pin 3
    idle(3, 8'h09);
    idle(8, 8'h01);
    rd(2'd0, 8'h01); rd(2'd1, 8'h01); rd(2'd2, 8'h01);
    // Set-wins: falling accept coincides with a FALL read
    cyc(8'h00, 0, 2'd0, 0, 2'd0, 16'd0, 0);
    idle(D, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd2, 8'h00);
    // Mask behaviour: fall enabled only
    wr_mask(16'h0100, 8'h00);
    idle(8, 8'h01);
    idle(8, 8'h00);
    cyc(8'h00, 1, 2'd3, 1, 2'd3, 16'h0000, 0);
    idle(3, 8'h00);
    rd(2'd1, 8'h00); rd(2'd2, 8'h00);
    // Reset mid-debounce with a pending RISE
    wr_mask(16'h00FF, 8'h00);
    idle(8, 8'h80);
    idle(3, 8'h00);
    cyc(8'h00, 0, 2'd0, 0, 2'd0, 16'd0, 1);
    rd(2'd3, 8'h00); rd(2'd1, 8'h00); rd(2'd2, 8'h00);
    idle(8, 8'h00);
    rd(2'd2, 8'h00);
    // Randomized traffic with slowly changing pins and occasional glitches
    p = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      logic re, we, r;
      logic [1:0] ra, wa;
      logic [15:0] wd;
      if ($urandom_range(0, 5) == 0) p[$urandom_range(0, 7)] ^= 1'b1;
      re = ($urandom_range(0, 2) == 0);
      ra = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 9) == 0);
      wa = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      r  = ($urandom_range(0, 499) == 0);
      cyc(p, re, ra, we, wa, wd, r);
    end
    idle(2, p);
    @(posedge clk);
    #2;
    done = 1;
    n_checks++;
    if (exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL rd_missing: %0d expected reads never presented, expected 0", exp_rd.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
